// File: rtl/pc_pkg.sv
// Shared constants for the parametrised up/down program counter.
package pc_pkg;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-count: step add/subtract with wrap or saturate handling.
module pc_next_calc
  import pc_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  pc,
  input  logic              up,
  input  logic [STEP_W-1:0] step,
  input  logic              sat_mode,
  output logic [WIDTH-1:0]  nxt,
  output logic              wrap_evt,
  output logic              clamp_evt
);
  logic [WIDTH:0]   step_ext, sum, diff;
  logic [WIDTH-1:0] raw;
  logic             ovf, unf;

  assign step_ext = (WIDTH+1)'(step);
  assign sum      = {1'b0, pc} + step_ext;
  // Borrow out of the extended subtraction is exactly pc < step.
  assign diff     = {1'b0, pc} - step_ext;

  always_comb begin
    ovf       = (up == DIR_UP) && sum[WIDTH];
    unf       = (up == DIR_DOWN) && diff[WIDTH];
    raw       = (up == DIR_UP) ? sum[WIDTH-1:0] : diff[WIDTH-1:0];
    nxt       = raw;
    wrap_evt  = 1'b0;
    clamp_evt = 1'b0;
    if (sat_mode == MODE_SAT) begin
      if (ovf) begin
        nxt       = '1;
        clamp_evt = 1'b1;
      end else if (unf) begin
        nxt       = '0;
        clamp_evt = 1'b1;
      end
    end else begin
      wrap_evt = ovf | unf;
    end
  end
endmodule

// File: rtl/pc_updown_param.sv
// Parametrised program counter: load > count > hold, with wrap/saturate mode and event pulses.
module pc_updown_param
  import pc_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               STEP_W      = 4,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter logic             SAT_DEFAULT = MODE_WRAP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              mode_wr,
  input  logic              mode_sat,
  output logic [WIDTH-1:0]  pc,
  output logic              at_max,
  output logic              at_min,
  output logic              wrapped,
  output logic              clamped,
  output logic              sat_mode
);
  logic [WIDTH-1:0] nxt;
  logic             wrap_evt, clamp_evt;

  pc_next_calc #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_calc (
    .pc        (pc),
    .up        (up),
    .step      (step),
    .sat_mode  (sat_mode),
    .nxt       (nxt),
    .wrap_evt  (wrap_evt),
    .clamp_evt (clamp_evt)
  );

  // Counting uses the pre-edge sat_mode; a mode write only affects later edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_VAL;
      wrapped  <= 1'b0;
      clamped  <= 1'b0;
      sat_mode <= SAT_DEFAULT;
    end else begin
      if (mode_wr) sat_mode <= mode_sat;
      if (load) begin
        pc      <= load_val;
        wrapped <= 1'b0;
        clamped <= 1'b0;
      end else if (en) begin
        pc      <= nxt;
        wrapped <= wrap_evt;
        clamped <= clamp_evt;
      end else begin
        wrapped <= 1'b0;
        clamped <= 1'b0;
      end
    end
  end

  assign at_max = &pc;
  assign at_min = ~|pc;
endmodule

// File: tb/tb_pc_updown_param.sv
// Scoreboard bench: driver pushes model results, monitor pops and compares after each edge.
module tb_pc_updown_param;
  localparam int WIDTH = 8;
  localparam int STEP_W = 4;
  localparam int MAXV = (1 << WIDTH) - 1;
  localparam logic [WIDTH-1:0] RESET_VAL = '0;
  localparam logic SAT_DEFAULT = 1'b0;

  logic clk = 1'b0, rst = 1'b1;
  logic en = 0, up = 0, load = 0, mode_wr = 0, mode_sat = 0;
  logic [STEP_W-1:0] step = '0;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] pc;
  logic at_max, at_min, wrapped, clamped, sat_mode;

  typedef struct {
    int pc;
    bit w;
    bit c;
    bit sat;
  } exp_t;
  exp_t q[$];

  int total = 0, bad = 0;
  int m_pc;
  bit m_sat;

  pc_updown_param #(.WIDTH(WIDTH), .STEP_W(STEP_W), .RESET_VAL(RESET_VAL),
                    .SAT_DEFAULT(SAT_DEFAULT)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .step(step), .load(load),
    .load_val(load_val), .mode_wr(mode_wr), .mode_sat(mode_sat), .pc(pc),
    .at_max(at_max), .at_min(at_min), .wrapped(wrapped), .clamped(clamped),
    .sat_mode(sat_mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one operation for the next rising edge and record its expected outcome.
  task automatic cyc(input bit i_en, input bit i_up, input int i_step, input bit i_load,
                     input int i_lv, input bit i_mwr, input bit i_msat);
    exp_t e;
    int t;
    @(negedge clk);
    en = i_en; up = i_up; step = STEP_W'(i_step); load = i_load;
    load_val = WIDTH'(i_lv); mode_wr = i_mwr; mode_sat = i_msat;
    e.w = 0; e.c = 0;
    if (i_load) m_pc = i_lv;
    else if (i_en) begin
      t = i_up ? m_pc + i_step : m_pc - i_step;
      if (t > MAXV) begin
        if (m_sat) begin m_pc = MAXV; e.c = 1; end
        else begin m_pc = t - (MAXV + 1); e.w = 1; end
      end else if (t < 0) begin
        if (m_sat) begin m_pc = 0; e.c = 1; end
        else begin m_pc = t + MAXV + 1; e.w = 1; end
      end else m_pc = t;
    end
    if (i_mwr) m_sat = i_msat;
    e.pc = m_pc; e.sat = m_sat;
    q.push_back(e);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc", int'(pc), e.pc);
      chk("wrapped", int'(wrapped), int'(e.w));
      chk("clamped", int'(clamped), int'(e.c));
      chk("sat_mode", int'(sat_mode), int'(e.sat));
      chk("at_max", int'(at_max), int'(e.pc == MAXV));
      chk("at_min", int'(at_min), int'(e.pc == 0));
    end
  end

  initial begin
    m_pc = int'(RESET_VAL); m_sat = SAT_DEFAULT;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pc0", int'(pc), int'(RESET_VAL));
    rst = 0;

    // Mid-cycle asynchronous reset from pc = 0x37
    cyc(0, 0, 0, 1, 8'h37, 0, 0);
    idle();
    @(posedge clk); #3;
    rst = 1; #1;
    chk("rst_async_pc", int'(pc), int'(RESET_VAL));
    chk("rst_wrapped", int'(wrapped), 0);
    chk("rst_clamped", int'(clamped), 0);
    chk("rst_sat", int'(sat_mode), int'(SAT_DEFAULT));
    m_pc = int'(RESET_VAL); m_sat = SAT_DEFAULT;
    @(negedge clk); rst = 0;
    cyc(1, 1, 1, 0, 0, 0, 0);

    // Wrap up then down
    cyc(0, 0, 0, 1, 8'hFD, 0, 0);
    cyc(1, 1, 5, 0, 0, 0, 0);
    idle();
    cyc(1, 0, 3, 0, 0, 0, 0);

    // Saturate
    cyc(0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 8'hFC, 0, 0);
    cyc(1, 1, 7, 0, 0, 0, 0);
    cyc(1, 1, 7, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 8'h05, 0, 0);
    cyc(1, 0, 15, 0, 0, 0, 0);

    // Load priority over count, then continue
    cyc(1, 1, 3, 1, 8'hA5, 0, 0);
    cyc(1, 1, 3, 0, 0, 0, 0);

    // Hold and zero step
    repeat (4) idle();
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);

    // Exact hit in both modes
    cyc(0, 0, 0, 1, 8'hFE, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 8'h01, 1, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);

    // Mode switch sat->wrap on the same edge as 0xFF + 1
    cyc(0, 0, 0, 1, 8'hFF, 1, 1);
    cyc(1, 1, 1, 0, 0, 1, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 9) < 8, 1'($urandom), int'($urandom_range(0, (1 << STEP_W) - 1)),
          $urandom_range(0, 9) == 0, int'($urandom_range(0, MAXV)),
          $urandom_range(0, 9) == 0, 1'($urandom));
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_updown_param.md
Name: pc_updown_param

Overview:
- Parametrised program counter; successor to the simple 4-bit up/down PC.
- Adds configurable width, external clock, step size and synchronous load.
- Adds enable, a selectable wrap/saturate mode and terminal-count flags.
- Sits in the sequencer datapath of the sequential-logic labs; feeds an instruction ROM address and branch/loop control.

Parameters:
- WIDTH, 8, counter width in bits (2..32).
- STEP_W, 4, width of the step input in bits; STEP_W <= WIDTH.
- RESET_VAL, 0, value loaded on reset; WIDTH bits.
- SAT_DEFAULT, 0, mode after reset: 0 = wrap, 1 = saturate.

Ports:
- clk  in  1  system clock; the block acts on rising edges.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- step  in  STEP_W  increment/decrement amount, unsigned; 0 means hold.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- mode_wr  in  1  latch mode_sat on this edge.
- mode_sat  in  1  new mode: 1 = saturate, 0 = wrap.
- pc  out  WIDTH  current count, registered.
- at_max  out  1  combinational: pc == all ones.
- at_min  out  1  combinational: pc == 0.
- wrapped  out  1  registered one-cycle pulse: the last update wrapped.
- clamped  out  1  registered one-cycle pulse: the last update saturated.
- sat_mode  out  1  current mode register.

Behaviour:
- Reset is asynchronous, active-high; clock clk. While rst = 1, regardless of clk:
  - pc = RESET_VAL
  - wrapped = 0, clamped = 0
  - sat_mode = SAT_DEFAULT
- Reset has priority over all inputs. Deassertion takes effect at the next rising edge.
- All state updates happen on the rising clk edge. No internal clocks, no delays inside the block.
- Priority per edge: load, then counting (en), then hold.
- load = 1:
  - pc <= load_val; wrapped <= 0; clamped <= 0.
  - en, up and step are ignored.
- load = 0, en = 1, count path. Compute the sum/difference at WIDTH+1 bits with step zero-extended.
  - up = 1: nxt = pc + step. Overflow when bit WIDTH is set.
  - up = 0: nxt = pc - step. Underflow when pc < step.
  - Wrap mode: pc <= nxt[WIDTH-1:0]. wrapped <= 1 if overflow or underflow, else 0. clamped <= 0.
  - Saturate mode, overflow: pc <= all ones; clamped <= 1.
  - Saturate mode, underflow: pc <= 0; clamped <= 1.
  - Saturate mode, no overflow/underflow: pc <= nxt; clamped <= 0. wrapped is always 0 in this mode.
- step = 0 with en = 1: pc holds. Both flags <= 0.
- en = 0 and load = 0: pc holds. Both flags <= 0, so each flag pulses for exactly one cycle.
- Latency: pc reflects an operation one cycle after the edge that samples it. at_max and at_min follow pc combinationally.
- mode_wr = 1: sat_mode <= mode_sat on the same edge. The count on that edge uses the old sat_mode.
- Exact hit: reaching the boundary exactly is not a wrap or a clamp (e.g. 0xFE + 1 = 0xFF, flags 0).
- Already saturated: pc = 0xFF, up, step 1, saturate mode gives pc = 0xFF and clamped = 1 again on every edge.
- Reset mid-operation: state returns to reset values immediately. Pending flags are cleared.

Decomposition:
- Shared package pc_pkg holds:
  - localparams MODE_WRAP = 1'b0, MODE_SAT = 1'b1
  - DIR_UP = 1'b1, DIR_DOWN = 1'b0
- One sub-module is natural: pc_next_calc. It is purely combinational.
  - Inputs: pc, up, step, sat_mode.
  - Outputs: nxt, wrap_evt, clamp_evt.
- The top module holds the registers, priority logic and mode register.

Test Plan:
- Reset: assert rst mid-cycle with pc = 0x37, then check:
  - pc = 0x00 immediately, without waiting for an edge
  - flags 0, sat_mode = SAT_DEFAULT
  - after release and one edge with en = 1, up = 1, step = 1, pc = 0x01
- Wrap up/down (wrap mode, WIDTH 8):
  - pc = 0xFD, step 5, up: pc = 0x02, wrapped pulses 1 for one cycle.
  - Then down, step 3: pc = 0xFF, wrapped = 1.
- Saturate:
  - mode_wr = 1, mode_sat = 1. pc = 0xFC, up, step 7: pc = 0xFF, clamped = 1, at_max = 1.
  - Repeat the edge: pc stays 0xFF, clamped = 1.
  - Down, step 15 from 0x05: pc = 0x00, at_min = 1.
- Priority: load = 1, load_val = 0xA5, en = 1, up = 1, step = 3 on the same edge gives pc = 0xA5 and flags 0. The next edge with load = 0 gives pc = 0xA8.
- Hold/zero step:
  - en = 0 for 4 edges: pc unchanged, flags 0.
  - en = 1, step = 0: pc unchanged.
  - Exact-hit case: pc 0xFE, step 1, up gives 0xFF with wrapped = 0 and clamped = 0.
- Mode switch timing: mode_wr = 1 (sat → wrap) on the same edge as 0xFF + 1. The result is clamped to 0xFF (old mode). The next 0xFF + 1 wraps to 0x00 with wrapped = 1.
